aes_serial_loader: RTL

- Synthesizable serial master that loads one plaintext block and one cipher key into the AES core's serial slave port: cs1 with mosi/misod for data, then cs2 with mosi/misok for the key.
- Waits for the core's doneenc/donedec pulses and checks encrypted/decrypted against expected values.
- Parametrised successor of the fixed 128/128 loader: key length follows Nk (128/192/256), the serial clock rate is programmable, either check can be enabled independently, and a completion timeout is included.
- Sits between the test/host controller and the Aes core.

---
 rtl/aes_serial_loader.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_serial_loader.sv
// Serial master that shifts a block on cs1 and a key on cs2 into the AES core,
// then waits for the core's done pulses and compares its results.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               begin a transaction (accepted only when idle)
//   chk_en[1:0]         bit0 = check encrypt, bit1 = check decrypt
//   data_in, key_in     block and key to send (latched at start)
//   exp_enc, exp_dec    expected core results (latched at start)
//   misod, misok        serial echo during the data / key phase
//   doneenc, donedec    core done pulses with encrypted / decrypted
//   sclk, cs1, cs2,     serial bus (chip-selects active low)
//   mosi
//   busy, done          status; done is a one-cycle pulse
//   passenc, passdec,   results, valid from done until the next start
//   timeout
//   data_echo, key_echo bits captured from misod / misok
module aes_serial_loader #(
  parameter int NK      = 4,
  parameter int BLOCK_W = 128,
  parameter int CLK_DIV = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           chk_en,
  input  logic [BLOCK_W-1:0]   data_in,
  input  logic [32*NK-1:0]     key_in,
  input  logic [BLOCK_W-1:0]   exp_enc,
  input  logic [BLOCK_W-1:0]   exp_dec,
  input  logic                 misod,
  input  logic                 misok,
  input  logic                 doneenc,
  input  logic                 donedec,
  input  logic [BLOCK_W-1:0]   encrypted,
  input  logic [BLOCK_W-1:0]   decrypted,
  output logic                 sclk,
  output logic                 cs1,
  output logic                 cs2,
  output logic                 mosi,
  output logic                 busy,
  output logic                 done,
  output logic                 passenc,
  output logic                 passdec,
  output logic                 timeout,
  output logic [BLOCK_W-1:0]   data_echo,
  output logic [32*NK-1:0]     key_echo
);

  localparam int KEY_W = 32 * NK;
  localparam int MAXW  = (BLOCK_W > KEY_W) ? BLOCK_W : KEY_W;
  localparam int CW    = (MAXW > 2) ? $clog2(MAXW) : 1;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] D_LAST   = CW'(BLOCK_W - 1);
  localparam logic [CW-1:0] K_LAST   = CW'(KEY_W - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    GAP,
    KEY,
    WAIT_DONE,
    REPORT
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]      divcnt;
  logic [CW-1:0]      bitcnt;
  logic [TW-1:0]      wcnt;
  logic [BLOCK_W-1:0] data_sr;
  logic [KEY_W-1:0]   key_sr;
  logic [BLOCK_W-1:0] exp_enc_r;
  logic [BLOCK_W-1:0] exp_dec_r;
  logic [1:0]         en_r;
  logic               seen_enc;
  logic               seen_dec;

  logic shifting;
  logic half_end;
  logic rise;
  logic fall;
  logic last_bit;
  logic take_enc;
  logic take_dec;
  logic all_seen;
  logic to_hit;

  // rise/fall mark the edges that drive sclk 0->1 and 1->0.
  always_comb begin
    shifting = (state == DATA) || (state == KEY);
    half_end = (divcnt == DIV_LAST);
    rise     = shifting && !sclk && half_end;
    fall     = shifting && sclk && half_end;
    last_bit = (state == KEY) ? (bitcnt == K_LAST)
                              : (bitcnt == D_LAST);
    take_enc = (state == WAIT_DONE) && en_r[0]
               && doneenc && !seen_enc;
    take_dec = (state == WAIT_DONE) && en_r[1]
               && donedec && !seen_dec;
    // Includes pulses arriving this cycle so the exit is not delayed.
    all_seen = (!en_r[0] || seen_enc || take_enc)
               && (!en_r[1] || seen_dec || take_dec);
    to_hit   = (wcnt == T_LAST);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (start) state_nx = DATA;
      DATA:      if (fall && last_bit) state_nx = GAP;
      GAP:       state_nx = KEY;
      KEY:       if (fall && last_bit) state_nx = WAIT_DONE;
      WAIT_DONE: if (all_seen || to_hit) state_nx = REPORT;
      REPORT:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign busy = (state != IDLE) && (state != REPORT);
  assign done = (state == REPORT);

  // The shift registers are pre-shifted so their MSB is always the next
  // bit to place on mosi at a falling sclk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk      <= 1'b0;
      cs1       <= 1'b1;
      cs2       <= 1'b1;
      mosi      <= 1'b0;
      passenc   <= 1'b0;
      passdec   <= 1'b0;
      timeout   <= 1'b0;
      data_echo <= '0;
      key_echo  <= '0;
      divcnt    <= '0;
      bitcnt    <= '0;
      wcnt      <= '0;
      data_sr   <= '0;
      key_sr    <= '0;
      exp_enc_r <= '0;
      exp_dec_r <= '0;
      en_r      <= '0;
      seen_enc  <= 1'b0;
      seen_dec  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            data_sr   <= data_in << 1;
            key_sr    <= key_in;
            exp_enc_r <= exp_enc;
            exp_dec_r <= exp_dec;
            en_r      <= chk_en;
            passenc   <= 1'b0;
            passdec   <= 1'b0;
            timeout   <= 1'b0;
            data_echo <= '0;
            key_echo  <= '0;
            seen_enc  <= 1'b0;
            seen_dec  <= 1'b0;
            divcnt    <= '0;
            bitcnt    <= '0;
            sclk      <= 1'b0;
            cs1       <= 1'b0;
            mosi      <= data_in[BLOCK_W-1];
          end
        end
        DATA: begin
          divcnt <= half_end ? '0 : divcnt + 1'b1;
          if (rise) begin
            sclk      <= 1'b1;
            data_echo <= {data_echo[BLOCK_W-2:0], misod};
          end
          if (fall) begin
            sclk <= 1'b0;
            if (last_bit) begin
              cs1    <= 1'b1;
              bitcnt <= '0;
              mosi   <= key_sr[KEY_W-1];
              key_sr <= key_sr << 1;
            end else begin
              bitcnt  <= bitcnt + 1'b1;
              mosi    <= data_sr[BLOCK_W-1];
              data_sr <= data_sr << 1;
            end
          end
        end
        GAP: begin
          cs2    <= 1'b0;
          divcnt <= '0;
        end
        KEY: begin
          divcnt <= half_end ? '0 : divcnt + 1'b1;
          if (rise) begin
            sclk     <= 1'b1;
            key_echo <= {key_echo[KEY_W-2:0], misok};
          end
          if (fall) begin
            sclk <= 1'b0;
            if (last_bit) begin
              cs2    <= 1'b1;
              mosi   <= 1'b0;
              bitcnt <= '0;
              wcnt   <= '0;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              mosi   <= key_sr[KEY_W-1];
              key_sr <= key_sr << 1;
            end
          end
        end
        WAIT_DONE: begin
          wcnt <= wcnt + 1'b1;
          if (take_enc) begin
            seen_enc <= 1'b1;
            passenc  <= (encrypted == exp_enc_r);
          end
          if (take_dec) begin
            seen_dec <= 1'b1;
            passdec  <= (decrypted == exp_dec_r);
          end
          if (to_hit && !all_seen) timeout <= 1'b1;
        end
        REPORT: ;
        default: ;
      endcase
    end
  end

endmodule
